multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the multicycle RV64 datapath: register file, 64-bit ALU and its ALU control decoder, sign extender and unified memory.
- Supports the subset R-type (add/sub/and/or/slt), ld, sd and beq.
- Issues all datapath strobes per cycle, including the 2-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory ready handshake and traps on illegal opcodes.

---
 rtl/multicycle_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the multicycle RV64 datapath.
// Sequences fetch, decode, memory, execute, writeback and branch states
// for R-type, ld, sd and beq. It waits on the memory ready handshake and
// traps on illegal opcodes or when the memory watchdog expires.
// Datapath strobes are registered from the next state. The handshake
// qualified strobes (IRWrite, PCWrite and the sd completion pulse) are
// combinational on mem_ready. Every strobe is forced low while rst_n is low.
// Optional build macro: PERF_CNT_EN adds cycle_cnt and instret_cnt.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        PCSource,
  output logic        instr_done,
  output logic        illegal,
`ifdef PERF_CNT_EN
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt,
`endif
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The counter only has to reach MEM_WAIT_MAX, because the FSM leaves at that value.
  localparam int CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);
  localparam bit WD_EN = (MEM_WAIT_MAX != 0);

  state_t           state_reg, state_next, out_state;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             wait_state, wd_expired;

  // Registered Moore strobes and the state flags used by the Mealy strobes.
  logic       memread_reg, memwrite_reg, iord_reg, memtoreg_reg, regwrite_reg;
  logic       alusrca_reg, pcsource_reg, pcwritecond_reg, done_reg, illegal_reg;
  logic       fetch_reg, write_reg;
  logic [1:0] alusrcb_reg, aluop_reg;

  logic       memread_next, memwrite_next, iord_next, memtoreg_next, regwrite_next;
  logic       alusrca_next, pcsource_next, pcwritecond_next, done_next, illegal_next;
  logic       fetch_next, write_next;
  logic [1:0] alusrcb_next, aluop_next;

  assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                      (state_reg == S_MEM_WRITE);
  assign wd_expired = WD_EN && (wait_cnt_reg == WAIT_LIMIT);

  // Next-state selection and watchdog counter update.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready)       state_next = S_DECODE;
        else if (wd_expired) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:           state_next = S_EXECUTE;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default:            state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        // The opcode is checked again here, so a corrupted IR cannot reach an undefined access.
        if (opcode == OP_LOAD)       state_next = S_MEM_READ;
        else if (opcode == OP_STORE) state_next = S_MEM_WRITE;
        else                         state_next = S_TRAP;
      end
      S_MEM_READ: begin
        if (mem_ready)       state_next = S_MEM_WB;
        else if (wd_expired) state_next = S_TRAP;
      end
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)       state_next = S_FETCH;
        else if (wd_expired) state_next = S_TRAP;
      end
      S_EXECUTE:   state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_TRAP;
    endcase

    if (mem_ready || (state_next != state_reg))
      wait_cnt_next = '0;
    else if (WD_EN && wait_state && !wd_expired)
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
  end

  // Decode the Moore strobes for the state entered at the next edge.
  always_comb begin
    out_state        = rst_n ? state_next : S_FETCH;
    memread_next     = 1'b0;
    memwrite_next    = 1'b0;
    iord_next        = 1'b0;
    memtoreg_next    = 1'b0;
    regwrite_next    = 1'b0;
    alusrca_next     = 1'b0;
    alusrcb_next     = 2'b00;
    aluop_next       = 2'b00;
    pcsource_next    = 1'b0;
    pcwritecond_next = 1'b0;
    done_next        = 1'b0;
    illegal_next     = 1'b0;
    fetch_next       = 1'b0;
    write_next       = 1'b0;
    case (out_state)
      S_FETCH: begin
        memread_next = 1'b1;
        alusrcb_next = 2'b01;
        fetch_next   = 1'b1;
      end
      S_DECODE: begin
        alusrcb_next = 2'b10;
      end
      S_MEM_ADDR: begin
        alusrca_next = 1'b1;
        alusrcb_next = 2'b10;
      end
      S_MEM_READ: begin
        memread_next = 1'b1;
        iord_next    = 1'b1;
      end
      S_MEM_WB: begin
        regwrite_next = 1'b1;
        memtoreg_next = 1'b1;
        done_next     = 1'b1;
      end
      S_MEM_WRITE: begin
        memwrite_next = 1'b1;
        iord_next     = 1'b1;
        write_next    = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_next = 1'b1;
        aluop_next   = 2'b10;
      end
      S_ALU_WB: begin
        regwrite_next = 1'b1;
        done_next     = 1'b1;
      end
      S_BRANCH: begin
        alusrca_next     = 1'b1;
        aluop_next       = 2'b01;
        pcwritecond_next = 1'b1;
        pcsource_next    = 1'b1;
        done_next        = 1'b1;
      end
      default: begin
        illegal_next = 1'b1;
      end
    endcase
  end

  // State, watchdog and registered strobes. Reset overrides every other condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
    memread_reg     <= memread_next;
    memwrite_reg    <= memwrite_next;
    iord_reg        <= iord_next;
    memtoreg_reg    <= memtoreg_next;
    regwrite_reg    <= regwrite_next;
    alusrca_reg     <= alusrca_next;
    alusrcb_reg     <= alusrcb_next;
    aluop_reg       <= aluop_next;
    pcsource_reg    <= pcsource_next;
    pcwritecond_reg <= pcwritecond_next;
    done_reg        <= done_next;
    illegal_reg     <= illegal_next;
    fetch_reg       <= fetch_next;
    write_reg       <= write_next;
  end

  // While rst_n is low, every output is gated to 0.
  assign MemRead     = rst_n & memread_reg;
  assign MemWrite    = rst_n & memwrite_reg;
  assign IorD        = rst_n & iord_reg;
  assign MemtoReg    = rst_n & memtoreg_reg;
  assign RegWrite    = rst_n & regwrite_reg;
  assign ALUSrcA     = rst_n & alusrca_reg;
  assign ALUSrcB     = {2{rst_n}} & alusrcb_reg;
  assign ALUOp       = {2{rst_n}} & aluop_reg;
  assign PCSource    = rst_n & pcsource_reg;
  assign PCWriteCond = rst_n & pcwritecond_reg;
  assign IRWrite     = rst_n & fetch_reg & mem_ready;
  assign PCWrite     = rst_n & fetch_reg & mem_ready;
  assign instr_done  = rst_n & (done_reg | (write_reg & mem_ready));
  assign illegal     = rst_n & illegal_reg;
  assign state       = state_reg;

`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt_reg, instret_cnt_reg;

  // Free-running cycle counter and retired-instruction counter. Both wrap modulo 2^64.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= 64'd0;
      instret_cnt_reg <= 64'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      if (instr_done) instret_cnt_reg <= instret_cnt_reg + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed test of the multicycle control FSM.
// The DUT is built with MEM_WAIT_MAX=4 so that the watchdog is reachable.
// When PERF_CNT_EN is defined, the bench also checks the performance counters.
module tb_multicycle_control;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, ALUSrcA, PCSource, instr_done, illegal;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  int tests = 0;
  int fails = 0;

  multicycle_control #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal(illegal),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    tick(); tick();
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++;
    if ({MemRead, IRWrite, PCWrite, ALUSrcB, instr_done, illegal} !== 7'd0) begin
      fails++; $display("FAIL reset_strobes: got %b want 0", {MemRead, IRWrite, PCWrite, ALUSrcB, instr_done, illegal});
    end
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    tests++;
    if ({MemRead, IorD, ALUSrcB, IRWrite} !== 5'b10010) begin
      fails++; $display("FAIL reset_fetch_out: got %b want 10010", {MemRead, IorD, ALUSrcB, IRWrite});
    end
    $display("[TB] reset: state=%0d MemRead=%b", state, MemRead);
  endtask

  task automatic test_add();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    int ndone = 0;
    opcode = OP_R; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (state !== exp_st[i]) begin fails++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      tests++;
      if (RegWrite !== (i == 3)) begin fails++; $display("FAIL add_regwrite[%0d]: got %b want %b", i, RegWrite, (i == 3)); end
      tests++;
      if (IRWrite !== (i == 0)) begin fails++; $display("FAIL add_irwrite[%0d]: got %b want %b", i, IRWrite, (i == 0)); end
      if (i == 2) begin
        tests++;
        if (ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
          fails++; $display("FAIL add_exec_sel: got op=%b a=%b b=%b want 10 1 00", ALUOp, ALUSrcA, ALUSrcB);
        end
      end
      if (i == 1) begin
        tests++;
        if (ALUSrcB !== 2'b10 || ALUSrcA !== 1'b0) begin
          fails++; $display("FAIL add_decode_sel: got a=%b b=%b want 0 10", ALUSrcA, ALUSrcB);
        end
      end
      if (instr_done === 1'b1) ndone++;
      tests++;
      if (instr_done !== (i == 3)) begin fails++; $display("FAIL add_done[%0d]: got %b want %b", i, instr_done, (i == 3)); end
      tick();
    end
    tests++;
    if (state !== 4'd0 || ndone != 1) begin
      fails++; $display("FAIL add_end: got state=%0d done=%0d want 0 1", state, ndone);
    end
    $display("[TB] add: end state=%0d done_pulses=%0d", state, ndone);
  endtask

  task automatic test_ld_stall();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LD;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      tests++;
      if (state !== exp_st[i]) begin fails++; $display("FAIL ld_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (exp_st[i] == 4'd3) begin
        tests++;
        if (MemRead !== 1'b1 || IorD !== 1'b1) begin
          fails++; $display("FAIL ld_memread[%0d]: got rd=%b iord=%b want 1 1", i, MemRead, IorD);
        end
      end
      if (exp_st[i] == 4'd2) begin
        tests++;
        if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
          fails++; $display("FAIL ld_addr_sel: got a=%b b=%b op=%b want 1 10 00", ALUSrcA, ALUSrcB, ALUOp);
        end
      end
      if (exp_st[i] == 4'd4) begin
        tests++;
        if (MemtoReg !== 1'b1 || RegWrite !== 1'b1 || MemRead !== 1'b0) begin
          fails++; $display("FAIL ld_wb: got m2r=%b rw=%b rd=%b want 1 1 0", MemtoReg, RegWrite, MemRead);
        end
      end
      tests++;
      if (instr_done !== (i == 7)) begin fails++; $display("FAIL ld_done[%0d]: got %b want %b", i, instr_done, (i == 7)); end
      tick();
    end
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL ld_end: got %0d want 0", state); end
    $display("[TB] ld with 3 stall cycles: end state=%0d", state);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8};
    int ndone = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = (i < 4) ? OP_SD : OP_BEQ;
      #1;
      tests++;
      if (state !== exp_st[i]) begin fails++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      tests++;
      if (MemWrite !== (exp_st[i] == 4'd5)) begin
        fails++; $display("FAIL b2b_memwrite[%0d]: got %b want %b", i, MemWrite, (exp_st[i] == 4'd5));
      end
      if (exp_st[i] == 4'd8) begin
        tests++;
        if (PCWriteCond !== 1'b1 || ALUOp !== 2'b01 || PCSource !== 1'b1 || RegWrite !== 1'b0) begin
          fails++; $display("FAIL b2b_branch: got pwc=%b op=%b src=%b rw=%b want 1 01 1 0", PCWriteCond, ALUOp, PCSource, RegWrite);
        end
      end
      if (instr_done === 1'b1) ndone++;
      tick();
    end
    tests++;
    if (ndone != 2 || state !== 4'd0) begin
      fails++; $display("FAIL b2b_done: got done=%0d state=%0d want 2 0", ndone, state);
    end
    $display("[TB] sd+beq: done_pulses=%0d end state=%0d", ndone, state);
  endtask

  task automatic test_trap();
    mem_ready = 1'b1; opcode = OP_BAD;
    tick(); // FETCH -> DECODE
    #1;
    tests++;
    if (state !== 4'd1) begin fails++; $display("FAIL trap_decode: got %0d want 1", state); end
    tick();
    tests++;
    if (state !== 4'd9 || illegal !== 1'b1) begin
      fails++; $display("FAIL trap_enter: got state=%0d illegal=%b want 9 1", state, illegal);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode = (i < 10) ? OP_R : OP_LD;
      #1;
      tests++;
      if ({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done} !== 15'd0 || state !== 4'd9 || illegal !== 1'b1) begin
        fails++; $display("FAIL trap_hold[%0d]: got state=%0d illegal=%b MemRead=%b want 9 1 0", i, state, illegal, MemRead);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    tests++;
    if (state !== 4'd0 || illegal !== 1'b0 || MemRead !== 1'b1) begin
      fails++; $display("FAIL trap_exit: got state=%0d illegal=%b rd=%b want 0 0 1", state, illegal, MemRead);
    end
    $display("[TB] illegal opcode: trapped and released, state=%0d", state);
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    mem_ready = 1'b1; opcode = OP_SD;
    tick(); tick(); tick(); // FETCH, DECODE, MEM_ADDR
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (state !== 4'd5 || MemWrite !== 1'b1 || instr_done !== 1'b0) begin
        fails++; $display("FAIL wr_stall[%0d]: got state=%0d wr=%b done=%b want 5 1 0", i, state, MemWrite, instr_done);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (state !== 4'd0 || MemWrite !== 1'b0) begin
      fails++; $display("FAIL wr_reset: got state=%0d wr=%b want 0 0", state, MemWrite);
    end
    rst_n = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (state !== exp_st[i] || MemWrite !== 1'b0 || instr_done !== (i == 3)) begin
        fails++; $display("FAIL wr_refetch[%0d]: got state=%0d wr=%b done=%b want %0d 0 %b", i, state, MemWrite, instr_done, exp_st[i], (i == 3));
      end
      tick();
    end
    $display("[TB] reset during sd stall: recovered, state=%0d", state);
  endtask

  task automatic test_watchdog();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (state !== 4'd0) begin fails++; $display("FAIL wd_fetch[%0d]: got %0d want 0", i, state); end
      tick();
    end
    tests++;
    if (state !== 4'd9 || illegal !== 1'b1) begin
      fails++; $display("FAIL wd_trap: got state=%0d illegal=%b want 9 1", state, illegal);
    end
    // A ready arriving in the limit cycle completes the fetch instead of trapping.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1;
    #1;
    tests++;
    if (IRWrite !== 1'b1) begin fails++; $display("FAIL wd_ready_ir: got %b want 1", IRWrite); end
    tick();
    tests++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      fails++; $display("FAIL wd_ready_wins: got state=%0d illegal=%b want 1 0", state, illegal);
    end
    $display("[TB] watchdog: limit-cycle ready gives state=%0d", state);
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    logic [6:0] ops [10] = '{OP_R, OP_LD, OP_SD, OP_BEQ, OP_R, OP_LD, OP_SD, OP_BEQ, OP_R, OP_BEQ};
    int         lat [10] = '{4, 5, 4, 3, 4, 5, 4, 3, 4, 3};
    do_reset();
    tests++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      fails++; $display("FAIL perf_reset: got cyc=%0d ret=%0d want 0 0", cycle_cnt, instret_cnt);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      opcode = ops[k];
      for (int c = 0; c < lat[k]; c++) tick();
    end
    tests++;
    if (instret_cnt !== 64'd10) begin fails++; $display("FAIL perf_instret: got %0d want 10", instret_cnt); end
    tests++;
    if (cycle_cnt !== 64'd39) begin fails++; $display("FAIL perf_cycles: got %0d want 39", cycle_cnt); end
    $display("[TB] perf: cycles=%0d instret=%0d", cycle_cnt, instret_cnt);
  endtask
`endif

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    test_reset();
    test_add();
    test_ld_stall();
    test_back_to_back();
    test_trap();
    test_reset_mid_write();
    test_watchdog();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
